sha2_padder: RTL and testbench

- Sits directly downstream of the byte-order converter stage, which presents message words MSB-first (first message byte in bits [511:504]).
- Accepts an AXI-Stream message of arbitrary byte length and emits complete 512-bit SHA-2 message blocks to the compression core.
- Each block is padded per FIPS 180-4: 0x80 marker, zero fill, then the 64-bit message bit-length in the final block.

---
 rtl/sha2_padder.sv | 133 +++++++++++++
 tb/tb_sha2_padder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_padder.sv
// SHA-2 message padder: turns an MSB-first AXI-Stream message into 512-bit blocks
// carrying the 0x80 marker, zero fill and the 64-bit bit-length in the final block.

module sha2_pad_lane #(
  parameter int IDX = 0,
  parameter int NW  = 7
) (
  input  logic [7:0]    din,
  input  logic [NW-1:0] n_keep,
  output logic [7:0]    dout
);
  // bytes before the cut pass through, the first dropped byte becomes the marker
  assign dout = (NW'(IDX) < n_keep)  ? din   :
                (NW'(IDX) == n_keep) ? 8'h80 : 8'h00;
endmodule

module sha2_padder #(
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 64
) (
  input  logic                    axis_aclk,
  input  logic                    axis_resetn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_block,
  output logic                    m_block_valid,
  output logic                    m_block_last,
  input  logic                    m_block_ready
);
  localparam int NB = DATA_WIDTH/8;
  localparam int CW = LEN_WIDTH-3;
  localparam int NW = $clog2(NB+1);

  typedef enum logic {S_DATA, S_EXTRA} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } blk_t;

  state_t          state, nxt_state;
  blk_t            out_q, nxt_out;
  logic            out_vld, nxt_vld;
  logic [CW-1:0]   cnt, nxt_cnt, pend_len, nxt_pend_len;
  logic            pend_mark, nxt_pend_mark;
  logic [NW-1:0]   n_keep;
  logic            run;
  logic [DATA_WIDTH-1:0] padded;
  logic [CW-1:0]   msg_len;
  logic            load_ok, fire;

  // leading run of ones in tkeep; anything after the first hole is ignored
  always_comb begin
    n_keep = '0;
    run    = 1'b1;
    for (int i = NB-1; i >= 0; i--) begin
      if (run && s_axis_tkeep[i]) n_keep = n_keep + NW'(1);
      else                        run    = 1'b0;
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_lane
    sha2_pad_lane #(.IDX(k), .NW(NW)) u_lane (
      .din   (s_axis_tdata[DATA_WIDTH-1-8*k -: 8]),
      .n_keep(n_keep),
      .dout  (padded[DATA_WIDTH-1-8*k -: 8])
    );
  end

  assign msg_len       = cnt + CW'(n_keep);
  assign load_ok       = !out_vld || m_block_ready;
  assign s_axis_tready = axis_resetn && (state == S_DATA) && load_ok;
  assign fire          = s_axis_tvalid && s_axis_tready;

  always_comb begin
    nxt_state     = state;
    nxt_out       = out_q;
    nxt_vld       = out_vld && !m_block_ready;
    nxt_cnt       = cnt;
    nxt_pend_len  = pend_len;
    nxt_pend_mark = pend_mark;
    case (state)
      S_DATA: if (fire) begin
        nxt_vld = 1'b1;
        if (!s_axis_tlast) begin
          nxt_out = '{data: s_axis_tdata, last: 1'b0};
          nxt_cnt = cnt + CW'(NB);
        end else if (n_keep <= NW'(NB-9)) begin
          nxt_out = '{data: {padded[DATA_WIDTH-1:LEN_WIDTH], msg_len, 3'b000}, last: 1'b1};
          nxt_cnt = '0;
        end else begin
          // no room for the length: emit data now, length block follows
          nxt_out       = '{data: padded, last: 1'b0};
          nxt_pend_len  = msg_len;
          nxt_pend_mark = (n_keep == NW'(NB));
          nxt_state     = S_EXTRA;
        end
      end
      S_EXTRA: if (load_ok) begin
        nxt_vld   = 1'b1;
        nxt_out   = '{data: {pend_mark, 7'b0, {(DATA_WIDTH-8-LEN_WIDTH){1'b0}}, pend_len, 3'b000},
                      last: 1'b1};
        nxt_cnt   = '0;
        nxt_state = S_DATA;
      end
      default: nxt_state = S_DATA;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state     <= S_DATA;
      out_q     <= '0;
      out_vld   <= 1'b0;
      cnt       <= '0;
      pend_len  <= '0;
      pend_mark <= 1'b0;
    end else begin
      state     <= nxt_state;
      out_q     <= nxt_out;
      out_vld   <= nxt_vld;
      cnt       <= nxt_cnt;
      pend_len  <= nxt_pend_len;
      pend_mark <= nxt_pend_mark;
    end
  end

  assign m_block       = out_q.data;
  assign m_block_last  = out_q.last;
  assign m_block_valid = out_vld;
endmodule

// File: tb/tb_sha2_padder.sv
// Bench for sha2_padder: constant vectors for single-beat messages, a byte-level
// FIPS 180-4 padding model for multi-beat messages, and reset/backpressure sequences.

module tb_sha2_padder;
  logic         clk = 1'b0;
  logic         axis_resetn;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [511:0] m_block;
  logic         m_block_valid, m_block_last, m_block_ready;

  sha2_padder #(.DATA_WIDTH(512), .LEN_WIDTH(64)) dut (
    .axis_aclk(clk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_block(m_block), .m_block_valid(m_block_valid), .m_block_last(m_block_last),
    .m_block_ready(m_block_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [511:0] blk; logic last; } exp_t;
  typedef struct {
    logic [511:0] tdata; logic [63:0] tkeep; int nblk;
    logic [511:0] b0; bit l0; logic [511:0] b1;
  } vec_t;

  exp_t        exp_q[$];
  logic [7:0]  msg[$];
  vec_t        tbl[7];
  int          total = 0, bad = 0;
  int          rmode = 0, phase = 0;

  task automatic chk(input string nm, input bit ok, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // ready pattern: 0 always, 1 the 1,0,0,1 cycle, 2 random, 3 held low
  initial begin
    m_block_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: m_block_ready = 1'b1;
        1: begin m_block_ready = (phase % 4 == 0) || (phase % 4 == 3); phase++; end
        2: m_block_ready = 1'($urandom_range(0, 1));
        default: m_block_ready = 1'b0;
      endcase
    end
  end

  // scoreboard pop and hold-stability check, sampled mid-cycle
  logic         hold_v = 1'b0, hold_last;
  logic [511:0] hold_blk;
  always @(negedge clk) begin
    exp_t e;
    if (!axis_resetn) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        chk("hold_valid", m_block_valid === 1'b1, 512'(m_block_valid), 512'd1);
        chk("hold_block", m_block === hold_blk && m_block_last === hold_last, m_block, hold_blk);
      end
      if (m_block_valid && m_block_ready) begin
        if (exp_q.size() == 0) chk("unexpected_block", 1'b0, m_block, 512'd0);
        else begin
          e = exp_q.pop_front();
          chk("block", m_block === e.blk, m_block, e.blk);
          chk("block_last", m_block_last === e.last, 512'(m_block_last), 512'(e.last));
        end
      end
      hold_v    = m_block_valid && !m_block_ready;
      hold_blk  = m_block;
      hold_last = m_block_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // reference padding on a flat byte stream
  task automatic model_push();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] b;
    int           nb;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int bi = 0; bi < nb; bi++) begin
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*bi+j];
      exp_q.push_back('{blk: b, last: (bi == nb-1)});
    end
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    int t = 0;
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && t < 300) begin @(negedge clk); t++; end
    if (!s_axis_tready) chk("tready_timeout", 1'b0, 512'd0, 512'd1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic rand_word(output logic [511:0] d);
    for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
  endtask

  task automatic send_msg(input int nfull, input int nlast);
    logic [511:0] d;
    logic [63:0]  k;
    msg.delete();
    for (int i = 0; i < 64*nfull + nlast; i++) msg.push_back(8'($urandom));
    model_push();
    for (int bi = 0; bi < nfull; bi++) begin
      for (int j = 0; j < 64; j++) d[511-8*j -: 8] = msg[64*bi+j];
      send_beat(d, {$urandom, $urandom}, 1'b0);
    end
    rand_word(d);
    k = {$urandom, $urandom};
    for (int j = 0; j < nlast; j++) begin
      d[511-8*j -: 8] = msg[64*nfull+j];
      k[63-j] = 1'b1;
    end
    if (nlast < 64) k[63-nlast] = 1'b0;
    send_beat(d, k, 1'b1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) chk("drain_timeout", 1'b0, 512'(exp_q.size()), 512'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{{24'h616263, {61{8'hA5}}}, 64'hE000_0000_0000_0000, 1,
               {32'h61626380, 416'h0, 64'h18}, 1'b1, 512'h0};
    tbl[1] = '{{64{8'h5A}}, 64'h0, 1, {8'h80, 440'h0, 64'h0}, 1'b1, 512'h0};
    tbl[2] = '{{{56{8'h3C}}, {8{8'hFF}}}, 64'hFFFF_FFFF_FFFF_FF00, 2,
               {{56{8'h3C}}, 8'h80, 56'h0}, 1'b0, {448'h0, 64'h1C0}};
    tbl[3] = '{{16{32'h0123_4567}}, 64'hFFFF_FFFF_FFFF_FFFF, 2,
               {16{32'h0123_4567}}, 1'b0, {8'h80, 440'h0, 64'h200}};
    tbl[4] = '{{{55{8'h77}}, {9{8'hEE}}}, 64'hFFFF_FFFF_FFFF_FE00, 1,
               {{55{8'h77}}, 8'h80, 64'h1B8}, 1'b1, 512'h0};
    tbl[5] = '{{16'hABCD, {62{8'h99}}}, 64'hC0FF_0000_0000_0000, 1,
               {16'hABCD, 8'h80, 424'h0, 64'h10}, 1'b1, 512'h0};
    tbl[6] = '{{{63{8'h42}}, 8'h24}, 64'hFFFF_FFFF_FFFF_FFFE, 2,
               {{63{8'h42}}, 8'h80}, 1'b0, {448'h0, 64'h1F8}};

    axis_resetn = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    #1 axis_resetn = 1'b0;
    #3;
    chk("rst_block", m_block === 512'd0, m_block, 512'd0);
    chk("rst_valid", m_block_valid === 1'b0, 512'(m_block_valid), 512'd0);
    chk("rst_last", m_block_last === 1'b0, 512'(m_block_last), 512'd0);
    chk("rst_tready", s_axis_tready === 1'b0, 512'(s_axis_tready), 512'd0);
    repeat (3) @(negedge clk);
    axis_resetn = 1'b1;
    @(posedge clk); #1;

    rmode = 0;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back('{blk: tbl[i].b0, last: tbl[i].l0});
      if (tbl[i].nblk == 2) exp_q.push_back('{blk: tbl[i].b1, last: 1'b1});
      send_beat(tbl[i].tdata, tbl[i].tkeep, 1'b1);
      chk("latency_valid", m_block_valid === 1'b1, 512'(m_block_valid), 512'd1);
      if (tbl[i].nblk == 2)
        chk("tready_extra", s_axis_tready === 1'b0, 512'(s_axis_tready), 512'd0);
      wait_drain();
    end

    // 131 bytes under 1,0,0,1 backpressure
    rmode = 1; phase = 0;
    send_msg(2, 3);
    wait_drain();

    rmode = 2;
    for (int r = 0; r < 10; r++) begin
      int nl;
      case (r % 5)
        0: nl = 0; 1: nl = 56; 2: nl = 64; 3: nl = 55;
        default: nl = $urandom_range(0, 64);
      endcase
      send_msg($urandom_range(0, 2), nl);
    end
    wait_drain();

    // reset while the length block is pending
    rmode = 3;
    repeat (2) begin @(posedge clk); #1; end
    send_beat(tbl[2].tdata, tbl[2].tkeep, 1'b1);
    chk("extra_a_valid", m_block_valid === 1'b1, 512'(m_block_valid), 512'd1);
    chk("extra_a_block", m_block === tbl[2].b0, m_block, tbl[2].b0);
    chk("extra_tready", s_axis_tready === 1'b0, 512'(s_axis_tready), 512'd0);
    @(negedge clk); #2;
    axis_resetn = 1'b0;
    #1;
    chk("mid_rst_valid", m_block_valid === 1'b0, 512'(m_block_valid), 512'd0);
    chk("mid_rst_block", m_block === 512'd0, m_block, 512'd0);
    chk("mid_rst_tready", s_axis_tready === 1'b0, 512'(s_axis_tready), 512'd0);
    repeat (3) @(negedge clk);
    axis_resetn = 1'b1;
    rmode = 0;
    repeat (10) @(negedge clk);
    chk("no_block_b", m_block_valid === 1'b0, 512'(m_block_valid), 512'd0);
    @(posedge clk); #1;
    exp_q.push_back('{blk: tbl[0].b0, last: 1'b1});
    send_beat(tbl[0].tdata, tbl[0].tkeep, 1'b1);
    chk("post_rst_latency", m_block_valid === 1'b1, 512'(m_block_valid), 512'd1);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
